ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter: a CPU port and a debug/loader port share one RAM.
// Each access takes IDLE -> ACCESS -> RESP; the CPU wins ties until debug has waited STARVE_LIMIT times.
module ram_arbiter #(
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   cpu_req,
   input  logic                                   cpu_write,
   input  logic [ADDR_W-1:0]                      cpu_addr,
   input  logic [DATA_W-1:0]                      cpu_wdata,
   output logic                                   cpu_ack,
   output logic [DATA_W-1:0]                      cpu_rdata,
   input  logic                                   dbg_req,
   input  logic                                   dbg_write,
   input  logic [ADDR_W-1:0]                      dbg_addr,
   input  logic [DATA_W-1:0]                      dbg_wdata,
   output logic                                   dbg_ack,
   output logic [DATA_W-1:0]                      dbg_rdata,
   output logic                                   ram_enable,
   output logic                                   ram_read,
   output logic                                   ram_write,
   output logic [ADDR_W-1:0]                      ram_addr,
   output logic [DATA_W-1:0]                      ram_wdata,
   input  logic [DATA_W-1:0]                      ram_rdata,
   output logic                                   busy,
   output logic                                   owner,
   output logic [1:0]                             fsm_state,
   output logic [$clog2(STARVE_LIMIT+1)-1:0]      starve_cnt
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_owner;
   logic             r_write;
   logic [SW-1:0]    r_starve_cnt;

   logic             w_any_req;
   logic             w_grant_dbg;
   logic             w_sel_write;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   // Debug wins only when it is alone or has been passed over STARVE_LIMIT times.
   assign w_any_req   = cpu_req | dbg_req;
   assign w_grant_dbg = dbg_req & (~cpu_req | (r_starve_cnt == LIMIT));
   assign w_sel_write = w_grant_dbg ? dbg_write : cpu_write;
   assign w_sel_addr  = w_grant_dbg ? dbg_addr  : cpu_addr;
   assign w_sel_wdata = w_grant_dbg ? dbg_wdata : cpu_wdata;

   assign busy       = (r_state != IDLE);
   assign owner      = r_owner;
   assign fsm_state  = r_state;
   assign starve_cnt = r_starve_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_write      <= 1'b0;
         r_starve_cnt <= '0;
         cpu_ack      <= 1'b0;
         cpu_rdata    <= '0;
         dbg_ack      <= 1'b0;
         dbg_rdata    <= '0;
         ram_enable   <= 1'b0;
         ram_read     <= 1'b0;
         ram_write    <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!dbg_req || w_grant_dbg) begin
                  r_starve_cnt <= '0;
               end else if (r_starve_cnt != LIMIT) begin
                  r_starve_cnt <= r_starve_cnt + 1'b1;
               end
               if (w_any_req) begin
                  // The RAM-side registers double as the transaction latch.
                  r_owner    <= w_grant_dbg;
                  r_write    <= w_sel_write;
                  ram_enable <= 1'b1;
                  ram_read   <= ~w_sel_write;
                  ram_write  <= w_sel_write;
                  ram_addr   <= w_sel_addr;
                  ram_wdata  <= w_sel_wdata;
                  r_state    <= ACCESS;
               end
            end
            ACCESS: begin
               ram_enable <= 1'b0;
               ram_read   <= 1'b0;
               ram_write  <= 1'b0;
               if (r_owner) begin
                  dbg_ack   <= 1'b1;
                  dbg_rdata <= r_write ? '0 : ram_rdata;
               end else begin
                  cpu_ack   <= 1'b1;
                  cpu_rdata <= r_write ? '0 : ram_rdata;
               end
               r_state <= RESP;
            end
            RESP: begin
               cpu_ack   <= 1'b0;
               dbg_ack   <= 1'b0;
               cpu_rdata <= '0;
               dbg_rdata <= '0;
               r_state   <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a combinational RAM model behind the arbiter,
// linear stimulus with hand-computed expectations checked by immediate assertions.
module tb_ram_arbiter;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_write;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              dbg_req, dbg_write;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_rdata;
   logic              ram_enable, ram_read, ram_write;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              busy, owner;
   logic [1:0]        fsm_state;
   logic [2:0]        starve_cnt;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .ram_enable(ram_enable), .ram_read(ram_read), .ram_write(ram_write),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy), .owner(owner), .fsm_state(fsm_state), .starve_cnt(starve_cnt)
   );

   // Clock and RAM model
   always #5 clock = ~clock;

   assign ram_rdata = mem[ram_addr];

   always @(posedge clock) begin
      if (ram_enable && ram_write) mem[ram_addr] <= ram_wdata;
   end

   // Driver helpers
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_drive(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cpu_req = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic dbg_drive(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      dbg_req = 1'b1; dbg_write = wr; dbg_addr = a; dbg_wdata = d;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
      mem[9'h005] = 32'h1234_5678;
      reset = 1'b1;
      cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_write = 0; dbg_addr = '0; dbg_wdata = '0;

      // Reset state
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_ram_enable", ram_enable, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_starve", starve_cnt, 0);
      reset = 1'b0;

      // Idle with no request stays idle
      tick(); tick();
      chk("idle_state", fsm_state, 0);
      chk("idle_strobes", {ram_enable, ram_read, ram_write, cpu_ack, dbg_ack}, 0);

      // CPU read of 0x005
      cpu_drive(1'b0, 9'h005, 32'h0);
      tick();
      chk("rd_acc_state", fsm_state, 1);
      chk("rd_acc_strobes", {ram_enable, ram_read, ram_write}, 3'b110);
      chk("rd_acc_addr", ram_addr, 9'h005);
      chk("rd_acc_busy", busy, 1);
      chk("rd_acc_owner", owner, 0);
      tick();
      chk("rd_resp_ack", {cpu_ack, dbg_ack}, 2'b10);
      chk("rd_resp_data", cpu_rdata, 32'h1234_5678);
      chk("rd_resp_strobes", {ram_enable, ram_read, ram_write}, 0);
      cpu_req = 0;
      tick();
      chk("rd_idle_ack", cpu_ack, 0);
      chk("rd_idle_busy", busy, 0);

      // Debug write of 0xDEADBEEF to 0x1FF, then CPU read back
      dbg_drive(1'b1, 9'h1FF, 32'hDEAD_BEEF);
      tick();
      chk("dw_acc_strobes", {ram_enable, ram_read, ram_write}, 3'b101);
      chk("dw_acc_addr", ram_addr, 9'h1FF);
      chk("dw_acc_wdata", ram_wdata, 32'hDEAD_BEEF);
      chk("dw_acc_owner", owner, 1);
      tick();
      chk("dw_resp_ack", {cpu_ack, dbg_ack}, 2'b01);
      chk("dw_resp_rdata", dbg_rdata, 0);
      dbg_req = 0;
      tick();
      cpu_drive(1'b0, 9'h1FF, 32'h0);
      tick(); tick();
      chk("rb_ack", cpu_ack, 1);
      chk("rb_data", cpu_rdata, 32'hDEAD_BEEF);
      chk("rb_owner", owner, 0);
      cpu_req = 0;
      tick();

      // Inputs changed during ACCESS do not disturb the latched transaction
      cpu_drive(1'b1, 9'h010, 32'hA5A5_A5A5);
      tick();
      cpu_addr = 9'h020; cpu_wdata = 32'h0; cpu_write = 1'b0;
      #2;
      chk("lat_addr", ram_addr, 9'h010);
      chk("lat_wdata", ram_wdata, 32'hA5A5_A5A5);
      chk("lat_write", ram_write, 1);
      tick();
      chk("lat_ack", cpu_ack, 1);
      chk("lat_rdata", cpu_rdata, 0);
      cpu_req = 0;
      tick();
      cpu_drive(1'b0, 9'h010, 32'h0);
      tick(); tick();
      chk("lat_readback", cpu_rdata, 32'hA5A5_A5A5);
      cpu_req = 0;
      tick();

      // Simultaneous single requests: CPU at T+2, debug at T+5
      cpu_drive(1'b0, 9'h1FF, 32'h0);
      dbg_drive(1'b0, 9'h005, 32'h0);
      tick();
      chk("sim_acc1_owner", owner, 0);
      chk("sim_acc1_starve", starve_cnt, 1);
      tick();
      chk("sim_t2_ack", {cpu_ack, dbg_ack}, 2'b10);
      chk("sim_t2_data", cpu_rdata, 32'hDEAD_BEEF);
      cpu_req = 0;
      tick();
      chk("sim_t3_ack", {cpu_ack, dbg_ack}, 2'b00);
      tick();
      chk("sim_acc2_owner", owner, 1);
      chk("sim_acc2_starve", starve_cnt, 0);
      tick();
      chk("sim_t5_ack", {cpu_ack, dbg_ack}, 2'b01);
      chk("sim_t5_data", dbg_rdata, 32'h1234_5678);
      dbg_req = 0;
      tick();

      // Both requests held: CPU x4, then debug, repeating
      cpu_drive(1'b0, 9'h005, 32'h0);
      dbg_drive(1'b0, 9'h1FF, 32'h0);
      for (int k = 0; k < 14; k++) begin
         logic       exp_dbg;
         logic [2:0] exp_cnt;
         exp_dbg = ((k % 5) == 4);
         exp_cnt = exp_dbg ? 3'd0 : 3'((k % 5) + 1);
         tick();
         chk($sformatf("held_owner_%0d", k), owner, exp_dbg);
         chk($sformatf("held_starve_%0d", k), starve_cnt, exp_cnt);
         tick();
         chk($sformatf("held_ack_%0d", k), {cpu_ack, dbg_ack}, exp_dbg ? 2'b01 : 2'b10);
         tick();
         chk($sformatf("held_idle_%0d", k), busy, 0);
      end
      chk("held_sat", starve_cnt, 4);
      cpu_req = 0; dbg_req = 0;
      tick();
      chk("starve_clear", starve_cnt, 0);

      // Reset during ACCESS aborts without an ack
      cpu_drive(1'b1, 9'h030, 32'h1111_1111);
      tick();
      chk("rst_mid_acc", fsm_state, 1);
      reset = 1'b1; cpu_req = 0;
      tick();
      chk("rst_mid_state", fsm_state, 0);
      chk("rst_mid_outs", {cpu_ack, dbg_ack, ram_enable, ram_read, ram_write, busy, owner}, 0);
      chk("rst_mid_addr", ram_addr, 0);
      chk("rst_mid_wdata", ram_wdata, 0);
      reset = 1'b0;
      tick();
      chk("rst_mid_noack", {cpu_ack, dbg_ack}, 0);
      cpu_drive(1'b0, 9'h005, 32'h0);
      tick(); tick();
      chk("post_rst_ack", cpu_ack, 1);
      chk("post_rst_data", cpu_rdata, 32'h1234_5678);
      cpu_req = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
